// File: rtl/ahb_req_arbiter.sv
// ahb_req_arbiter
//   Two-requester round-robin arbiter and single-transfer sequencer sitting in
//   front of the AHB-lite master's processor-side port. One NONSEQ SINGLE
//   transfer is issued per grant. The FSM walks it through the address and
//   data phases, then returns read data and status to the granted requester.
//   A watchdog aborts a data phase that the slave stalls for WAIT_LIMIT cycles.
//
// Ports
//   HCLK, HRESETn            clock, async active-low reset
//   REQn_VALID/ADDR/WDATA/   requester n transfer, held until REQn_DONE;
//     WRITE/SIZE             sampled only in the grant cycle
//   REQn_DONE                one-cycle completion pulse to requester n
//   RSP_RDATA/ERR/TIMEOUT    completion status, valid with DONE, held after
//   PADDR/PWDATA/PWRITE/     processor-side request to the AHB master
//     PSIZE/PTRANS/PBURST
//   HREADY/HRESP/HRDATA      bus response
//   GRANT                    index of the current or last granted requester
module ahb_req_arbiter #(
  parameter int DATA_W     = 32,
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 5
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              REQ0_VALID,
  input  logic [DATA_W-1:0] REQ0_ADDR,
  input  logic [DATA_W-1:0] REQ0_WDATA,
  input  logic              REQ0_WRITE,
  input  logic [2:0]        REQ0_SIZE,
  input  logic              REQ1_VALID,
  input  logic [DATA_W-1:0] REQ1_ADDR,
  input  logic [DATA_W-1:0] REQ1_WDATA,
  input  logic              REQ1_WRITE,
  input  logic [2:0]        REQ1_SIZE,
  output logic              REQ0_DONE,
  output logic              REQ1_DONE,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic              RSP_TIMEOUT,
  output logic [DATA_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  output logic              PWRITE,
  output logic [2:0]        PSIZE,
  output logic [1:0]        PTRANS,
  output logic [2:0]        PBURST,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [DATA_W-1:0] HRDATA,
  output logic              GRANT
);

  localparam int         NUM_REQ    = 2;
  localparam logic [1:0] TRN_IDLE   = 2'b00;
  localparam logic [1:0] TRN_NONSEQ = 2'b10;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              write;
    logic [2:0]        size;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t               state, state_nxt;
  req_t [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   done_q;
  logic [CNT_W-1:0]     wait_cnt;
  logic                 win_idx;
  logic                 grant_en, addr_ack, cmpl, tmo;

  assign req_valid = {REQ1_VALID, REQ0_VALID};
  assign req[0]    = '{addr: REQ0_ADDR, wdata: REQ0_WDATA, write: REQ0_WRITE, size: REQ0_SIZE};
  assign req[1]    = '{addr: REQ1_ADDR, wdata: REQ1_WDATA, write: REQ1_WRITE, size: REQ1_SIZE};

  assign REQ0_DONE = done_q[0];
  assign REQ1_DONE = done_q[1];

  // Contention goes to the requester that was not granted last; a lone
  // requester wins outright (req_valid[1] is its index when only one is set).
  always_comb begin
    if (&req_valid) win_idx = ~GRANT;
    else            win_idx = req_valid[1];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    addr_ack  = 1'b0;
    cmpl      = 1'b0;
    tmo       = 1'b0;
    case (state)
      S_IDLE: if (|req_valid) begin
        grant_en  = 1'b1;
        state_nxt = S_ADDR;
      end
      S_ADDR: if (HREADY) begin
        addr_ack  = 1'b1;
        state_nxt = S_DATA;
      end
      S_DATA: begin
        // HRESP=1 with HREADY=0 is the first half of a two-cycle error
        // response and is deliberately not treated as completion.
        if (HREADY) begin
          cmpl      = 1'b1;
          state_nxt = S_IDLE;
        end else if (wait_cnt == CNT_W'(WAIT_LIMIT - 1)) begin
          // This stall edge is the WAIT_LIMIT-th one.
          tmo       = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      PSIZE       <= '0;
      PTRANS      <= TRN_IDLE;
      PBURST      <= '0;
      GRANT       <= 1'b1;
      done_q      <= '0;
      RSP_RDATA   <= '0;
      RSP_ERR     <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      done_q <= '0;
      PBURST <= '0;

      if (grant_en) begin
        PADDR  <= req[win_idx].addr;
        PWDATA <= req[win_idx].wdata;
        PWRITE <= req[win_idx].write;
        PSIZE  <= req[win_idx].size;
        PTRANS <= TRN_NONSEQ;
        GRANT  <= win_idx;
      end

      // Only PTRANS drops after the address phase; PWDATA and the rest stay
      // put through the data phase.
      if (addr_ack) PTRANS <= TRN_IDLE;

      if (state_nxt != S_DATA)
        wait_cnt <= '0;
      else if (state == S_DATA && !HREADY)
        wait_cnt <= wait_cnt + CNT_W'(1);

      if (cmpl) begin
        done_q[GRANT] <= 1'b1;
        RSP_RDATA     <= PWRITE ? '0 : HRDATA;
        RSP_ERR       <= HRESP;
        RSP_TIMEOUT   <= 1'b0;
      end

      if (tmo) begin
        done_q[GRANT] <= 1'b1;
        RSP_RDATA     <= '0;
        RSP_ERR       <= 1'b1;
        RSP_TIMEOUT   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_req_arbiter.sv
module tb_ahb_req_arbiter;

  localparam int DW = 32;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          REQ0_VALID, REQ0_WRITE, REQ1_VALID, REQ1_WRITE;
  logic [DW-1:0] REQ0_ADDR, REQ0_WDATA, REQ1_ADDR, REQ1_WDATA;
  logic [2:0]    REQ0_SIZE, REQ1_SIZE;
  logic          REQ0_DONE, REQ1_DONE, RSP_ERR, RSP_TIMEOUT, PWRITE, GRANT;
  logic [DW-1:0] RSP_RDATA, PADDR, PWDATA, HRDATA;
  logic [2:0]    PSIZE, PBURST;
  logic [1:0]    PTRANS;
  logic          HREADY, HRESP;

  ahb_req_arbiter #(.DATA_W(DW), .WAIT_LIMIT(16), .CNT_W(5)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .REQ0_VALID(REQ0_VALID), .REQ0_ADDR(REQ0_ADDR), .REQ0_WDATA(REQ0_WDATA),
    .REQ0_WRITE(REQ0_WRITE), .REQ0_SIZE(REQ0_SIZE),
    .REQ1_VALID(REQ1_VALID), .REQ1_ADDR(REQ1_ADDR), .REQ1_WDATA(REQ1_WDATA),
    .REQ1_WRITE(REQ1_WRITE), .REQ1_SIZE(REQ1_SIZE),
    .REQ0_DONE(REQ0_DONE), .REQ1_DONE(REQ1_DONE),
    .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSIZE(PSIZE),
    .PTRANS(PTRANS), .PBURST(PBURST),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .GRANT(GRANT)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int            idx;
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input int idx, input logic [DW-1:0] rdata, input logic err, input logic tmo);
    exp_t e;
    e.idx = idx; e.rdata = rdata; e.err = err; e.tmo = tmo;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every DONE pulse consumes one expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (HRESETn && (REQ0_DONE || REQ1_DONE)) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {30'd0, REQ1_DONE, REQ0_DONE}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done_vec",    {30'd0, REQ1_DONE, REQ0_DONE}, (e.idx == 1) ? 32'd2 : 32'd1);
          chk("done_grant",  {31'd0, GRANT},       DW'(e.idx));
          chk("rsp_rdata",   RSP_RDATA,            e.rdata);
          chk("rsp_err",     {31'd0, RSP_ERR},     {31'd0, e.err});
          chk("rsp_timeout", {31'd0, RSP_TIMEOUT}, {31'd0, e.tmo});
        end
      end
    end
  end

  // Bounded wait for the next DONE; leaves the caller on that negedge.
  task automatic wait_done(output int which, input int budget);
    which = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge HCLK);
      if (REQ0_DONE || REQ1_DONE) begin
        which = REQ1_DONE ? 1 : 0;
        return;
      end
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int which;
    int order [4] = '{0, 1, 0, 1};

    HRESETn = 1'b0;
    REQ0_VALID = 0; REQ0_ADDR = '0; REQ0_WDATA = '0; REQ0_WRITE = 0; REQ0_SIZE = '0;
    REQ1_VALID = 0; REQ1_ADDR = '0; REQ1_WDATA = '0; REQ1_WRITE = 0; REQ1_SIZE = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;

    // Reset state
    repeat (2) @(negedge HCLK);
    chk("rst_ptrans", {30'd0, PTRANS}, 32'd0);
    chk("rst_paddr",  PADDR,  32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_pctl",   {25'd0, PBURST, PSIZE, PWRITE}, 32'd0);
    chk("rst_grant",  {31'd0, GRANT}, 32'd1);
    chk("rst_rsp",    {29'd0, REQ1_DONE | REQ0_DONE, RSP_ERR, RSP_TIMEOUT}, 32'd0);
    chk("rst_rdata",  RSP_RDATA, 32'd0);
    HRESETn = 1'b1;

    // 1: REQ0 write, zero wait states
    @(negedge HCLK);
    REQ0_VALID = 1; REQ0_ADDR = 32'h10; REQ0_WDATA = 32'hDEAD_BEEF;
    REQ0_WRITE = 1; REQ0_SIZE = 3'b010;
    push(0, 32'd0, 1'b0, 1'b0);
    @(negedge HCLK);
    chk("t1_nonseq", {30'd0, PTRANS}, 32'd2);
    chk("t1_paddr",  PADDR,  32'h10);
    chk("t1_pwdata", PWDATA, 32'hDEAD_BEEF);
    chk("t1_pctl",   {28'd0, PSIZE, PWRITE}, {28'd0, 3'b010, 1'b1});
    chk("t1_grant",  {31'd0, GRANT}, 32'd0);
    @(negedge HCLK);
    chk("t1_idle_in_data", {30'd0, PTRANS}, 32'd0);
    chk("t1_pwdata_hold",  PWDATA, 32'hDEAD_BEEF);
    chk("t1_no_done_yet",  {31'd0, REQ0_DONE}, 32'd0);
    @(negedge HCLK);
    chk("t1_done_lat", {31'd0, REQ0_DONE}, 32'd1);
    REQ0_VALID = 0;
    @(negedge HCLK);
    chk("t1_done_pulse", {30'd0, REQ1_DONE, REQ0_DONE}, 32'd0);
    chk("t1_no_regrant", {30'd0, PTRANS}, 32'd0);

    // 2: REQ1 read with three wait states
    REQ1_VALID = 1; REQ1_ADDR = 32'h40; REQ1_WRITE = 0; REQ1_SIZE = 3'b010;
    REQ1_WDATA = 32'h0BAD_0BAD;
    push(1, 32'h1234_5678, 1'b0, 1'b0);
    @(negedge HCLK);
    chk("t2_paddr", PADDR, 32'h40);
    chk("t2_grant", {31'd0, GRANT}, 32'd1);
    @(negedge HCLK);
    HREADY = 0;
    repeat (3) @(negedge HCLK);
    chk("t2_no_done_wait", {31'd0, REQ1_DONE}, 32'd0);
    HREADY = 1; HRDATA = 32'h1234_5678;
    @(negedge HCLK);
    chk("t2_done_after_ready", {31'd0, REQ1_DONE}, 32'd1);
    REQ1_VALID = 0; HRDATA = '0;
    @(negedge HCLK);

    // 3: both requesters held, four transfers alternate starting with 0
    REQ0_VALID = 1; REQ0_ADDR = 32'h100; REQ0_WDATA = 32'hA0; REQ0_WRITE = 1;
    REQ1_VALID = 1; REQ1_ADDR = 32'h200; REQ1_WDATA = 32'hB1; REQ1_WRITE = 1;
    for (int i = 0; i < 4; i++) push(order[i], 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_done(which, 10);
      chk("rr_order", DW'(which), DW'(order[i]));
    end
    REQ0_VALID = 0; REQ1_VALID = 0;
    @(negedge HCLK);

    // 4: two-cycle ERROR response on a REQ0 read
    REQ0_VALID = 1; REQ0_ADDR = 32'h80; REQ0_WRITE = 0;
    push(0, 32'd0, 1'b1, 1'b0);
    @(negedge HCLK);
    @(negedge HCLK);
    HREADY = 0; HRESP = 1;
    @(negedge HCLK);
    chk("t4_first_err_ignored", {31'd0, REQ0_DONE}, 32'd0);
    HREADY = 1;
    @(negedge HCLK);
    chk("t4_err_done", {31'd0, REQ0_DONE}, 32'd1);
    REQ0_VALID = 0; HRESP = 0;
    @(negedge HCLK);
    chk("t4_single_done", {31'd0, REQ0_DONE}, 32'd0);

    // 5: watchdog, HREADY held low in the data phase
    REQ1_VALID = 1; REQ1_ADDR = 32'hC0; REQ1_WRITE = 1; REQ1_WDATA = 32'h77;
    push(1, 32'd0, 1'b1, 1'b1);
    @(negedge HCLK);
    @(negedge HCLK);
    HREADY = 0;
    repeat (15) @(negedge HCLK);
    chk("t5_no_done_15", {31'd0, REQ1_DONE}, 32'd0);
    @(negedge HCLK);
    chk("t5_done_16", {31'd0, REQ1_DONE}, 32'd1);
    REQ1_VALID = 0; HREADY = 1;
    @(negedge HCLK);
    chk("t5_back_idle", {30'd0, PTRANS}, 32'd0);

    // 6: reset in the data phase, then a normal grant
    REQ1_VALID = 1; REQ1_ADDR = 32'hE0; REQ1_WDATA = 32'h55;
    @(negedge HCLK);
    @(negedge HCLK);
    HREADY = 0;
    @(negedge HCLK);
    #2 HRESETn = 0;
    #1;
    chk("t6_rst_ptrans", {30'd0, PTRANS}, 32'd0);
    chk("t6_rst_paddr",  PADDR,  32'd0);
    chk("t6_rst_pwdata", PWDATA, 32'd0);
    chk("t6_rst_grant",  {31'd0, GRANT}, 32'd1);
    REQ1_VALID = 0; HREADY = 1;
    REQ0_VALID = 1; REQ0_ADDR = 32'h20; REQ0_WRITE = 0; HRDATA = 32'hCAFE_F00D;
    @(negedge HCLK);
    push(0, 32'hCAFE_F00D, 1'b0, 1'b0);
    HRESETn = 1;
    @(negedge HCLK);
    chk("t6_regrant_nonseq", {30'd0, PTRANS}, 32'd2);
    chk("t6_regrant_paddr",  PADDR, 32'h20);
    wait_done(which, 5);
    chk("t6_done_idx", DW'(which), 32'd0);
    REQ0_VALID = 0;

    repeat (3) @(negedge HCLK);
    chk("sb_drained", DW'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ahb_req_arbiter.md
Name: ahb_req_arbiter

Overview:
Two-requester round-robin arbiter and transfer sequencer in front of the AHB-lite master's processor-side port (PADDR/PWDATA/PWRITE/PSIZE/PTRANS/PBURST). It grants one requester at a time and drives a single NONSEQ transfer through the address and data phases. It watches the bus HREADY/HRESP, then returns read data and status to the granted requester. A wait-state watchdog aborts transfers on which the slave stalls too long.

Parameters:
DATA_W, 32, width of address and data buses
WAIT_LIMIT, 16, max consecutive HREADY=0 cycles in data phase before abort (>=1)
CNT_W, 5, wait counter width; must hold WAIT_LIMIT

Ports:
HCLK  in  1  bus clock, all state on rising edge
HRESETn  in  1  asynchronous active-low reset
REQ0_VALID  in  1  requester 0 has a transfer pending; held until REQ0_DONE
REQ0_ADDR  in  DATA_W  requester 0 address
REQ0_WDATA  in  DATA_W  requester 0 write data
REQ0_WRITE  in  1  requester 0 direction, 1=write
REQ0_SIZE  in  3  requester 0 HSIZE encoding
REQ1_VALID / REQ1_ADDR / REQ1_WDATA / REQ1_WRITE / REQ1_SIZE  in  1/DATA_W/DATA_W/1/3  same for requester 1
REQ0_DONE  out  1  one-cycle completion pulse to requester 0
REQ1_DONE  out  1  one-cycle completion pulse to requester 1
RSP_RDATA  out  DATA_W  read data of completed transfer, valid with DONE
RSP_ERR  out  1  error status, valid with DONE
RSP_TIMEOUT  out  1  watchdog abort status, valid with DONE
PADDR  out  DATA_W  to master
PWDATA  out  DATA_W  to master
PWRITE  out  1  to master
PSIZE  out  3  to master
PTRANS  out  2  to master: 2'b00 IDLE, 2'b10 NONSEQ
PBURST  out  3  to master: constant 3'b000 SINGLE
HREADY  in  1  bus ready, from mux
HRESP  in  1  bus response, 1=ERROR
HRDATA  in  DATA_W  bus read data
GRANT  out  1  index of the current or last granted requester

Behaviour:
- All outputs are registered. Reset values:
  - PTRANS=IDLE, PADDR=0, PWDATA=0, PWRITE=0, PSIZE=0, PBURST=0.
  - DONE pulses=0, RSP_*=0.
  - GRANT=1, so requester 0 wins the first tie.
  - Wait counter=0, state=IDLE.
- FSM IDLE -> ADDR -> DATA -> IDLE:
  - IDLE: PTRANS=IDLE. If any VALID=1 at an edge, select the winner and latch its ADDR/WDATA/WRITE/SIZE into the P* registers. Set PTRANS=NONSEQ, update GRANT, go to ADDR. Latency from VALID to NONSEQ on PTRANS is 1 cycle.
  - ADDR: hold all P* signals. At the first edge with HREADY=1, set PTRANS=IDLE and go to DATA. PWDATA holds through DATA.
  - DATA: at an edge with HREADY=1:
    - Capture HRDATA into RSP_RDATA (reads only; writes leave RSP_RDATA=0) and HRESP into RSP_ERR.
    - Pulse DONE[GRANT] for 1 cycle and return to IDLE.
    - A new grant may be issued in the same cycle that DONE is high (the next IDLE edge).
- Round-robin:
  - Only one VALID set: grant it.
  - Both set: grant the index != GRANT.
  - GRANT changes only on a grant.
- Watchdog:
  - Wait counter increments on each DATA-state edge with HREADY=0 and clears on leaving DATA.
  - When the counter reaches WAIT_LIMIT while HREADY=0: pulse DONE[GRANT] with RSP_ERR=1 and RSP_TIMEOUT=1, RSP_RDATA=0. Go to IDLE.
  - RSP_TIMEOUT=0 on normal completions.
- HRESP=1 with HREADY=0 (first error cycle) is ignored. Completion occurs on the second cycle (HREADY=1, HRESP=1), giving RSP_ERR=1.
- Requester inputs are sampled only at grant. Changes afterwards have no effect on the transfer in flight.
- VALID dropped before DONE: the transfer still completes and DONE still pulses.
- Asynchronous reset mid-transfer: immediate return to reset values. No DONE is issued for the aborted transfer.
- RSP_* hold their value until the next completion.

Test Plan:
- Reset, then REQ0 write (ADDR=0x0000_0010, WDATA=0xDEAD_BEEF, SIZE=3'b010), HREADY=1 -> PTRANS=NONSEQ for exactly 1 cycle with PADDR=0x10. REQ0_DONE pulses 2 cycles after NONSEQ, with RSP_ERR=0 and GRANT=0.
- REQ0 and REQ1 both held VALID for 4 transfers -> grant order 0,1,0,1 and DONE pulses alternate with no starvation.
- REQ1 read at 0x40, slave inserts 3 wait states then HRDATA=0x1234_5678 -> REQ1_DONE on the cycle after HREADY returns high, RSP_RDATA=0x1234_5678.
- Slave gives a two-cycle ERROR response (HRESP=1/HREADY=0, then HRESP=1/HREADY=1) -> single DONE with RSP_ERR=1, RSP_TIMEOUT=0.
- HREADY held 0 in data phase with WAIT_LIMIT=16 -> DONE on the 16th stall cycle with RSP_ERR=1 and RSP_TIMEOUT=1, then the FSM is back in IDLE.
- HRESETn asserted mid-DATA -> P* signals zero and PTRANS=IDLE immediately. No DONE is issued. After release, a pending REQ0 is granted normally.
